// File: rtl/cond_unit.sv
// Conditional-execution stage: holds the NZCV status register and gates PC, register and
// memory writes by the instruction condition. Define COND_FLAG_SPLIT_EN for separate NZ/CV writes.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
`ifdef COND_FLAG_SPLIT_EN
    input  logic [1:0] flag_w,
`else
    input  logic       flag_w,
`endif
    input  logic       pc_s,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Decode looks only at the registered flags, so an instruction never sees its own result.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign pc_src    = pc_s & cond_ex;
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= RESET_FLAGS;
        end else begin
`ifdef COND_FLAG_SPLIT_EN
            if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
`else
            if (flag_w & cond_ex) flags <= alu_flags;
`endif
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: condition-decode table plus reset/write-ordering sequences.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cond, alu_flags;
`ifdef COND_FLAG_SPLIT_EN
    logic [1:0] flag_w;
`else
    logic       flag_w;
`endif
    logic       pc_s, reg_w, mem_w, no_write;
    logic       pc_src, reg_write, mem_write, cond_ex;
    logic [3:0] flags;

    int n_cmp = 0;
    int n_bad = 0;

    cond_unit #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .rst(rst), .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
        .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
        .cond_ex(cond_ex), .flags(flags)
    );

    always #5 clk = ~clk;

    // preset flags, condition, requests {pc_s,reg_w,mem_w,no_write},
    // expected {cond_ex,pc_src,reg_write,mem_write}
    typedef struct packed {
        logic [3:0] f;
        logic [3:0] cond;
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle();
        cond = 4'b1110; alu_flags = 4'b0000; flag_w = '0;
        pc_s = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    endtask

    // Load flags through an always-pass flag-setting instruction.
    task automatic load(input logic [3:0] f);
        @(negedge clk);
        idle();
        cond = 4'b1110; alu_flags = f; flag_w = '1;
        @(posedge clk);
        #1;
        flag_w = '0;
        check("load", flags, f);
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 4'b0000, 4'b1110, 4'b1111}; // EQ
        tbl[1]  = '{4'b0100, 4'b0001, 4'b1110, 4'b0000}; // NE
        tbl[2]  = '{4'b0010, 4'b0010, 4'b1110, 4'b1111}; // CS
        tbl[3]  = '{4'b0000, 4'b0011, 4'b1110, 4'b1111}; // CC
        tbl[4]  = '{4'b1000, 4'b0100, 4'b1110, 4'b1111}; // MI
        tbl[5]  = '{4'b1000, 4'b0101, 4'b1110, 4'b0000}; // PL
        tbl[6]  = '{4'b0001, 4'b0110, 4'b1110, 4'b1111}; // VS
        tbl[7]  = '{4'b0001, 4'b0111, 4'b1110, 4'b0000}; // VC
        tbl[8]  = '{4'b0010, 4'b1000, 4'b1110, 4'b1111}; // HI
        tbl[9]  = '{4'b0010, 4'b1001, 4'b1110, 4'b0000}; // LS
        tbl[10] = '{4'b1000, 4'b1010, 4'b1110, 4'b0000}; // GE
        tbl[11] = '{4'b1000, 4'b1011, 4'b1110, 4'b1111}; // LT
        tbl[12] = '{4'b1000, 4'b1100, 4'b1110, 4'b0000}; // GT
        tbl[13] = '{4'b1000, 4'b1101, 4'b1110, 4'b1111}; // LE
        tbl[14] = '{4'b1001, 4'b1010, 4'b1110, 4'b1111}; // GE, N=V=1
        tbl[15] = '{4'b0110, 4'b1000, 4'b1110, 4'b0000}; // HI with Z
        tbl[16] = '{4'b0110, 4'b1001, 4'b1110, 4'b1111}; // LS with Z
        tbl[17] = '{4'b1001, 4'b1100, 4'b1110, 4'b1111}; // GT
        tbl[18] = '{4'b0000, 4'b1110, 4'b1111, 4'b1101}; // AL, no_write
        tbl[19] = '{4'b1111, 4'b1111, 4'b1110, 4'b0000}; // reserved
        tbl[20] = '{4'b0000, 4'b1110, 4'b1010, 4'b1101}; // AL, partial requests

        // Reset before any clock edge
        idle();
        rst = 1'b1;
        cond = 4'b0000;
        #1;
        check("rst_flags", flags, 4'b0000);
        check("rst_eq", {3'b0, cond_ex}, 4'b0000);
        cond = 4'b0001;
        #1;
        check("rst_ne", {3'b0, cond_ex}, 4'b0001);
        cond = 4'b1110; reg_w = 1'b1;
        #1;
        check("rst_al_regw", {3'b0, reg_write}, 4'b0001);
        @(negedge clk);
        rst = 1'b0;

        // Decode table
        for (int i = 0; i < 21; i++) begin
            load(tbl[i].f);
            @(negedge clk);
            cond = tbl[i].cond;
            {pc_s, reg_w, mem_w, no_write} = tbl[i].req;
            #1;
            check($sformatf("vec%0d", i), {cond_ex, pc_src, reg_write, mem_write}, tbl[i].exp);
            check($sformatf("vec%0d_flags", i), flags, tbl[i].f);
        end

        // Compare then branch
        load(4'b0000);
        @(negedge clk);
        idle();
        cond = 4'b1110; alu_flags = 4'b0100; flag_w = '1;
        #1;
        check("cmp_prewrite", flags, 4'b0000);
        @(posedge clk);
        #1;
        check("cmp_flags", flags, 4'b0100);
        flag_w = '0; cond = 4'b0000; pc_s = 1'b1;
        #1;
        check("branch_pc_src", {3'b0, pc_src}, 4'b0001);

        // Failed condition blocks writes
        load(4'b0000);
        @(negedge clk);
        idle();
        cond = 4'b0000; flag_w = '1; alu_flags = 4'b1111; mem_w = 1'b1;
        #1;
        check("fail_ce_mw", {2'b0, cond_ex, mem_write}, 4'b0000);
        @(posedge clk);
        #1;
        check("fail_flags", flags, 4'b0000);

        // Same-cycle write uses pre-write flags: NE passes, then NE fails on the new Z
        @(negedge clk);
        idle();
        cond = 4'b0001; flag_w = '1; alu_flags = 4'b0100;
        @(posedge clk);
        #1;
        check("ne_write", flags, 4'b0100);
        alu_flags = 4'b0000;
        @(posedge clk);
        #1;
        check("ne_blocked", flags, 4'b0100);

        // Partial flag write
        load(4'b0011);
        @(negedge clk);
        idle();
        cond = 4'b1110; alu_flags = 4'b1100;
`ifdef COND_FLAG_SPLIT_EN
        flag_w = 2'b10;
        @(posedge clk);
        #1;
        check("split_nz", flags, 4'b1111);
        @(negedge clk);
        flag_w = 2'b01; alu_flags = 4'b0000;
        @(posedge clk);
        #1;
        check("split_cv", flags, 4'b1100);
`else
        flag_w = 1'b1;
        @(posedge clk);
        #1;
        check("whole_write", flags, 4'b1100);
`endif

        // Mid-operation reset with a write held
        load(4'b1010);
        @(negedge clk);
        idle();
        cond = 4'b0000; flag_w = '1; alu_flags = 4'b0100; pc_s = 1'b1;
        #1;
        check("pre_rst_pc", {3'b0, pc_src}, 4'b0000);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", flags, 4'b0000);
        check("rst_eq_eval", {3'b0, cond_ex}, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_no_write", flags, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        cond = 4'b1110;
        @(posedge clk);
        #1;
        check("post_rst_write", flags, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
